// File: rtl/gray_counter_ctrl.sv
// Prescaled N-bit up/down counter with load, wrap/saturate limits and Gray or
// binary LED output. One count step per DIST enabled clock cycles.
module gray_counter_ctrl #(
  parameter int N    = 4,
  parameter int DIST = 100000000,
  parameter int PW   = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         sat,
  input  logic         out_bin,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] leds,
  output logic         tick,
  output logic         tc,
  output logic         wrap
);

  localparam logic [PW-1:0] PCNT_LAST = PW'(DIST - 1);
  localparam logic [N-1:0]  ALL_ONES  = '1;

  logic [PW-1:0] pcnt;
  logic [N-1:0]  bin_q;
  logic [N-1:0]  next_bin;
  logic          next_wrap;
  logic          step;

  // Prescaler: a load restarts the period so the next step is a full DIST away.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (load) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        tick <= 1'b1;
      end else begin
        pcnt <= pcnt + PW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // A load on the tick cycle swallows that step.
  assign step = tick & en & ~load;

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_val;
    end else if (step) begin
      if (dir) begin
        if (bin_q == ALL_ONES) begin
          if (!sat) begin
            next_bin  = '0;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = bin_q + N'(1);
        end
      end else begin
        if (bin_q == '0) begin
          if (!sat) begin
            next_bin  = ALL_ONES;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = bin_q - N'(1);
        end
      end
    end
  end

  // leds is re-encoded every cycle so an out_bin change shows without a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q <= '0;
      leds  <= '0;
      wrap  <= 1'b0;
    end else begin
      bin_q <= next_bin;
      leds  <= out_bin ? next_bin : (next_bin ^ (next_bin >> 1));
      wrap  <= next_wrap;
    end
  end

  assign tc = dir ? (bin_q == ALL_ONES) : (bin_q == '0);

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Self-checking bench for gray_counter_ctrl (N=4, DIST=4): an integer-level
// model checked every cycle plus hand-computed directed expectations.
module tb_gray_counter_ctrl;

  localparam int N    = 4;
  localparam int DIST = 4;
  localparam int PW   = 2;
  localparam int MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic         sat = 1'b0;
  logic         out_bin = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] leds;
  logic         tick;
  logic         tc;
  logic         wrap;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  gray_counter_ctrl #(.N(N), .DIST(DIST), .PW(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .out_bin(out_bin),
    .load(load), .load_val(load_val), .leds(leds), .tick(tick), .tc(tc),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] gray(int c);
    logic [N-1:0] b;
    b = N'(c);
    return b ^ (b >> 1);
  endfunction

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count is a plain integer, the prescaler a running count of enabled
  // cycles since reset/load; a tick follows every DIST-th enabled cycle.
  int m_ens;
  int m_count;
  bit m_tick;
  bit m_wrap;
  bit m_outbin;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ens    <= 0;
      m_count  <= 0;
      m_tick   <= 1'b0;
      m_wrap   <= 1'b0;
      m_outbin <= 1'b0;
    end else begin
      m_outbin <= out_bin;
      m_wrap   <= 1'b0;
      if (load) begin
        m_count <= int'(load_val);
        m_ens   <= 0;
        m_tick  <= 1'b0;
      end else begin
        if (m_tick && en) begin
          if (dir) begin
            if (m_count < MAXV) m_count <= m_count + 1;
            else if (!sat) begin
              m_count <= 0;
              m_wrap  <= 1'b1;
            end
          end else begin
            if (m_count > 0) m_count <= m_count - 1;
            else if (!sat) begin
              m_count <= MAXV;
              m_wrap  <= 1'b1;
            end
          end
        end
        if (en) begin
          m_ens  <= m_ens + 1;
          m_tick <= ((m_ens + 1) % DIST) == 0;
        end else begin
          m_tick <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_leds", leds, m_outbin ? N'(m_count) : gray(m_count));
      check("model_tick", N'(tick), N'(m_tick));
      check("model_wrap", N'(wrap), N'(m_wrap));
      check("model_tc", N'(tc), N'(dir ? (m_count == MAXV) : (m_count == 0)));
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(string name, output int waited);
    waited = 0;
    while (tick !== 1'b1 && waited < 20) begin
      cyc(1);
      waited++;
    end
    check(name, N'(tick), N'(1));
  endtask

  logic [N-1:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};
  logic [N-1:0] down_seq [3] = '{4'b0001, 4'b0000, 4'b0000};

  initial begin
    int w;
    logic [N-1:0] prev;
    logic [N-1:0] frozen;

    #2 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_leds", leds, 4'b0000);
    check("rst_tick", N'(tick), N'(0));
    check("rst_wrap", N'(wrap), N'(0));
    check("rst_tc_up", N'(tc), N'(0));

    // Reset release and full up-count wrap.
    cyc(3);
    rst = 1'b1;
    en  = 1'b1;
    dir = 1'b1;
    sat = 1'b0;
    prev = '0;
    for (int i = 0; i < 16; i++) begin
      wait_tick("up_tick", w);
      if (i == 0) check("first_tick_lat", N'(w), N'(4));
      cyc(1);
      check("up_leds", leds, up_seq[i]);
      check("up_onebit", N'($countones(leds ^ prev) == 1), N'(1));
      check("up_wrap", N'(wrap), N'(i == 15));
      prev = leds;
    end

    // Load then count down into saturation.
    load = 1'b1;
    load_val = 4'b0010;
    dir = 1'b0;
    sat = 1'b1;
    cyc(1);
    load = 1'b0;
    check("load_leds", leds, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      wait_tick("down_tick", w);
      cyc(1);
      check("down_leds", leds, down_seq[i]);
      check("down_wrap", N'(wrap), N'(0));
    end
    check("down_tc", N'(tc), N'(1));

    // Load coinciding with a tick: load wins, period restarts.
    dir = 1'b1;
    sat = 1'b0;
    wait_tick("coll_tick", w);
    load = 1'b1;
    load_val = 4'b1010;
    cyc(1);
    load = 1'b0;
    check("coll_leds", leds, 4'b1111);
    check("coll_no_tick", N'(tick), N'(0));
    wait_tick("coll_next_tick", w);
    check("coll_lat", N'(w), N'(4));
    cyc(1);
    check("coll_step", leds, 4'b1110);

    // Freeze with the prescaler at 2.
    cyc(1);
    en = 1'b0;
    frozen = leds;
    cyc(10);
    check("freeze_leds", leds, frozen);
    en = 1'b1;
    wait_tick("freeze_tick", w);
    check("freeze_lat", N'(w), N'(2));
    cyc(1);
    check("freeze_step", leds, 4'b1010);

    // Output mode switch without a step.
    load = 1'b1;
    load_val = 4'b1011;
    cyc(1);
    load = 1'b0;
    check("mode_gray", leds, 4'b1110);
    out_bin = 1'b1;
    cyc(1);
    check("mode_bin", leds, 4'b1011);
    check("mode_wrap", N'(wrap), N'(0));
    out_bin = 1'b0;
    cyc(1);
    check("mode_back", leds, 4'b1110);

    // Asynchronous reset between edges.
    load = 1'b1;
    load_val = 4'b0111;
    cyc(1);
    load = 1'b0;
    check("pre_rst_leds", leds, 4'b0100);
    #2 rst = 1'b0;
    #1;
    check("arst_leds", leds, 4'b0000);
    check("arst_tick", N'(tick), N'(0));
    check("arst_wrap", N'(wrap), N'(0));
    cyc(2);
    rst = 1'b1;
    wait_tick("post_rst_tick", w);
    check("post_rst_lat", N'(w), N'(4));
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
